// File: rtl/cart_scan_pkg.sv
// Shared types and constants for the cart-detect byte streamer.
package cart_scan_pkg;

  // Scan sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_e;

  // Detector address that every beat past the first 8191 is pinned to.
  // The detectors use address 0 as their clear, so the stream must never
  // wrap back to 0.
  localparam logic [12:0] DET_ADDR_SAT = 13'h1FFF;

endpackage

// File: rtl/cart_scan_streamer.sv
// Cart-detect byte streamer: after a cart load, walks the stored ROM image
// through a request/acknowledge read port and emits one detector beat per
// byte, in order from offset 0, then reports done.
// Optional feature macro: CART_SCAN_READY_EN adds a det_ready back-pressure
// input; without it the detectors are assumed to always accept a beat.
module cart_scan_streamer
  import cart_scan_pkg::*;
#(
  parameter int MEM_AW = 16,
  parameter int DET_AW = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       cart_size,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic [DET_AW-1:0] det_addr,
  output logic [7:0]        det_data,
  output logic              det_enable,
`ifdef CART_SCAN_READY_EN
  input  logic              det_ready,
`endif
  output logic              busy,
  output logic              done
);

  // Largest scannable image: 2**MEM_AW bytes. idx/len carry one extra bit
  // so a full-size image terminates without overflow.
  localparam logic [MEM_AW:0] MAX_LEN = {1'b1, {MEM_AW{1'b0}}};
  // First index whose detector address is pinned to the saturation value.
  localparam logic [MEM_AW:0] SAT_IDX = (MEM_AW+1)'(DET_ADDR_SAT);

  state_e            state_q, state_d;
  logic [MEM_AW:0]   idx_q, idx_d;
  logic [MEM_AW:0]   len_q, len_d;
  logic [7:0]        byte_q, byte_d;
  logic [MEM_AW:0]   start_len;
  logic              beat_ok;

`ifdef CART_SCAN_READY_EN
  assign beat_ok = det_ready;
`else
  assign beat_ok = 1'b1;
`endif

  // Clamp the requested length to the addressable image size.
  assign start_len = (cart_size > 32'(MAX_LEN)) ? MAX_LEN
                                                : cart_size[MEM_AW:0];

  // State, index, length and captured byte registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the byte register is a single flop stage,
  // not a memory, so it is reset along with the rest to keep det_data at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      byte_q  <= byte_d;
    end
  end

  // Next-state logic and Moore outputs.
  // NOTE: every signal written here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    byte_d     = byte_q;
    mem_rd     = 1'b0;
    det_enable = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    mem_addr   = idx_q[MEM_AW-1:0];
    det_data   = byte_q;
    det_addr   = (idx_q < SAT_IDX) ? idx_q[DET_AW-1:0] : DET_AW'(DET_ADDR_SAT);

    unique case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (start) begin
          len_d   = start_len;
          idx_d   = '0;
          state_d = (start_len == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        mem_rd = 1'b1;
        busy   = 1'b1;
        if (mem_ack) begin
          byte_d  = mem_data;
          state_d = EMIT;
        end
      end
      EMIT: begin
        det_enable = 1'b1;
        busy       = 1'b1;
        if (beat_ok) begin
          if ((idx_q + 1'b1) == len_q) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
